// File: rtl/decode_sequencer.sv
// decode_sequencer
//   Front end of the decode stage. Walks the head of the prefetch byte queue,
//   absorbing legacy prefixes and a single 0x0F escape one byte per cycle,
//   then waits for the opcode length logic and issues the whole instruction
//   to the micro stage, popping the consumed bytes.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   dec_flush           synchronous pipeline clear (jump / exception)
//   cs_db               default operand/address size (1 = 32-bit)
//   fetch, fetch_valid  queue head bytes (byte0 in [7:0]) and valid count
//   length_ready        decoder length valid for the current opcode
//   consume_length      opcode..imm byte count, qualified by length_ready
//   micro_busy          micro stage stall
//   fetch_accept        bytes popped this cycle (combinational)
//   dec_valid           one-cycle issue strobe, dec_length = total length
//   dec_operand_32bit   cs_db ^ 0x66 seen
//   dec_address_32bit   cs_db ^ 0x67 seen
//   dec_prefix_*        latched prefix state (snapshot during dec_valid)
//   dec_exception_gp    one-cycle strobe, instruction longer than MAX_LEN
module decode_sequencer #(
  parameter int MAX_LEN     = 15,
  parameter int FETCH_BYTES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     dec_flush,
  input  logic                     cs_db,
  input  logic [8*FETCH_BYTES-1:0] fetch,
  input  logic [3:0]               fetch_valid,
  input  logic                     length_ready,
  input  logic [3:0]               consume_length,
  input  logic                     micro_busy,
  output logic [3:0]               fetch_accept,
  output logic                     dec_valid,
  output logic [3:0]               dec_length,
  output logic                     dec_operand_32bit,
  output logic                     dec_address_32bit,
  output logic [1:0]               dec_prefix_group_1_rep,
  output logic                     dec_prefix_group_1_lock,
  output logic [2:0]               dec_prefix_group_2_seg,
  output logic                     dec_prefix_2byte,
  output logic [3:0]               dec_prefix_count,
  output logic                     dec_exception_gp
);

  localparam logic [4:0] MAX_L    = 5'(MAX_LEN);
  localparam logic [2:0] SEG_NONE = 3'd7;

  typedef enum logic [1:0] {S_PREFIX, S_OPCODE, S_EXC} state_t;

  state_t     state, n_state;

  // working prefix state
  logic [2:0] seg_q, n_seg;
  logic [1:0] rep_q, n_rep;
  logic       lock_q, n_lock;
  logic       op_q, n_op;
  logic       ad_q, n_ad;
  logic       two_q, n_two;
  logic [3:0] cnt_q, n_cnt;

  // visible copies of the 0x66/0x67 flags
  logic       op_o, ad_o;

  logic       issue, exc;
  logic [7:0] byte0;
  logic [4:0] total;
  logic [4:0] cnt_inc;
  logic       is_prefix;

  // only byte0 is inspected; the rest of the head window belongs to the decoder
  logic       unused_fetch;
  assign unused_fetch = ^fetch[8*FETCH_BYTES-1:8];

  assign byte0   = fetch[7:0];
  assign total   = {1'b0, cnt_q} + {1'b0, consume_length};
  assign cnt_inc = {1'b0, cnt_q} + 5'd1;

  always_comb begin
    is_prefix = 1'b0;
    case (byte0)
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3: is_prefix = 1'b1;
      default: is_prefix = 1'b0;
    endcase
  end

  always_comb begin
    n_state      = state;
    n_seg        = seg_q;
    n_rep        = rep_q;
    n_lock       = lock_q;
    n_op         = op_q;
    n_ad         = ad_q;
    n_two        = two_q;
    n_cnt        = cnt_q;
    fetch_accept = 4'd0;
    issue        = 1'b0;
    exc          = 1'b0;

    if (!rst && !dec_flush) begin
      case (state)
        S_PREFIX: begin
          if (fetch_valid != 4'd0) begin
            if (is_prefix || (byte0 == 8'h0F && !two_q)) begin
              fetch_accept = 4'd1;
              n_cnt        = cnt_inc[3:0];
              case (byte0)
                8'h26: n_seg  = 3'd0;
                8'h2E: n_seg  = 3'd1;
                8'h36: n_seg  = 3'd2;
                8'h3E: n_seg  = 3'd3;
                8'h64: n_seg  = 3'd4;
                8'h65: n_seg  = 3'd5;
                8'h66: n_op   = 1'b1;
                8'h67: n_ad   = 1'b1;
                8'hF0: n_lock = 1'b1;
                8'hF2: n_rep  = 2'd2;
                8'hF3: n_rep  = 2'd1;
                default: n_two = 1'b1;  // 0x0F escape
              endcase
              // no room left for an opcode byte
              if (cnt_inc >= MAX_L) begin
                n_state = S_EXC;
                exc     = 1'b1;
              end
            end else begin
              // opcode byte (including a second 0x0F); nothing consumed yet
              n_state = S_OPCODE;
            end
          end
        end

        S_OPCODE: begin
          if (length_ready && !micro_busy && fetch_valid >= consume_length) begin
            if (total > MAX_L) begin
              n_state = S_EXC;
              exc     = 1'b1;
            end else begin
              fetch_accept = consume_length;
              issue        = 1'b1;
              n_state      = S_PREFIX;
              n_seg        = SEG_NONE;
              n_rep        = 2'd0;
              n_lock       = 1'b0;
              n_op         = 1'b0;
              n_ad         = 1'b0;
              n_two        = 1'b0;
              n_cnt        = 4'd0;
            end
          end
        end

        default: ;  // S_EXC: parked until flush
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || dec_flush) begin
      state                   <= S_PREFIX;
      seg_q                   <= SEG_NONE;
      rep_q                   <= 2'd0;
      lock_q                  <= 1'b0;
      op_q                    <= 1'b0;
      ad_q                    <= 1'b0;
      two_q                   <= 1'b0;
      cnt_q                   <= 4'd0;
      dec_prefix_group_2_seg  <= SEG_NONE;
      dec_prefix_group_1_rep  <= 2'd0;
      dec_prefix_group_1_lock <= 1'b0;
      op_o                    <= 1'b0;
      ad_o                    <= 1'b0;
      dec_prefix_2byte        <= 1'b0;
      dec_prefix_count        <= 4'd0;
      dec_valid               <= 1'b0;
      dec_length              <= 4'd0;
      dec_exception_gp        <= 1'b0;
    end else begin
      state  <= n_state;
      seg_q  <= n_seg;
      rep_q  <= n_rep;
      lock_q <= n_lock;
      op_q   <= n_op;
      ad_q   <= n_ad;
      two_q  <= n_two;
      cnt_q  <= n_cnt;
      // Outputs follow the working state, except on issue where they hold the
      // pre-clear values so the micro stage sees the issued instruction's prefixes.
      if (issue) begin
        dec_prefix_group_2_seg  <= seg_q;
        dec_prefix_group_1_rep  <= rep_q;
        dec_prefix_group_1_lock <= lock_q;
        op_o                    <= op_q;
        ad_o                    <= ad_q;
        dec_prefix_2byte        <= two_q;
        dec_prefix_count        <= cnt_q;
      end else begin
        dec_prefix_group_2_seg  <= n_seg;
        dec_prefix_group_1_rep  <= n_rep;
        dec_prefix_group_1_lock <= n_lock;
        op_o                    <= n_op;
        ad_o                    <= n_ad;
        dec_prefix_2byte        <= n_two;
        dec_prefix_count        <= n_cnt;
      end
      dec_valid        <= issue;
      dec_length       <= issue ? total[3:0] : 4'd0;
      dec_exception_gp <= exc;
    end
  end

  assign dec_operand_32bit = cs_db ^ op_o;
  assign dec_address_32bit = cs_db ^ ad_o;

endmodule

// File: tb/tb_decode_sequencer.sv
module tb_decode_sequencer;

  logic        clk = 1'b0;
  logic        rst, dec_flush, cs_db;
  logic [63:0] fetch;
  logic [3:0]  fetch_valid;
  logic        length_ready;
  logic [3:0]  consume_length;
  logic        micro_busy;
  logic [3:0]  fetch_accept;
  logic        dec_valid;
  logic [3:0]  dec_length;
  logic        dec_operand_32bit, dec_address_32bit;
  logic [1:0]  dec_prefix_group_1_rep;
  logic        dec_prefix_group_1_lock;
  logic [2:0]  dec_prefix_group_2_seg;
  logic        dec_prefix_2byte;
  logic [3:0]  dec_prefix_count;
  logic        dec_exception_gp;

  int vec = 0;
  int err = 0;
  logic [7:0] q[$];
  int cap = 8;

  always #5 clk = ~clk;

  decode_sequencer #(.MAX_LEN(15), .FETCH_BYTES(8)) dut (
    .clk(clk), .rst(rst), .dec_flush(dec_flush), .cs_db(cs_db),
    .fetch(fetch), .fetch_valid(fetch_valid), .length_ready(length_ready),
    .consume_length(consume_length), .micro_busy(micro_busy),
    .fetch_accept(fetch_accept), .dec_valid(dec_valid), .dec_length(dec_length),
    .dec_operand_32bit(dec_operand_32bit), .dec_address_32bit(dec_address_32bit),
    .dec_prefix_group_1_rep(dec_prefix_group_1_rep),
    .dec_prefix_group_1_lock(dec_prefix_group_1_lock),
    .dec_prefix_group_2_seg(dec_prefix_group_2_seg),
    .dec_prefix_2byte(dec_prefix_2byte), .dec_prefix_count(dec_prefix_count),
    .dec_exception_gp(dec_exception_gp)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // queue head model: byte0 is the oldest byte
  task automatic refresh();
    int n;
    fetch = '0;
    for (int i = 0; i < 8; i++)
      if (i < q.size()) fetch[i*8 +: 8] = q[i];
    n = (q.size() < cap) ? q.size() : cap;
    fetch_valid = 4'(n);
  endtask

  task automatic tick();
    int a;
    a = int'(fetch_accept);
    @(posedge clk); #1;
    for (int i = 0; i < a; i++) if (q.size() > 0) void'(q.pop_front());
    refresh();
  endtask

  task automatic chk_acc(input string tag, input int exp);
    #1 chk(tag, {28'd0, fetch_accept}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; dec_flush = 0; cs_db = 0; length_ready = 0; consume_length = 0;
    micro_busy = 0;
    q = '{8'h66};
    refresh();
    chk_acc("rst_acc", 0);
    tick(); tick();
    rst = 0;
    chk("rst_valid", dec_valid, 0);
    chk("rst_seg", dec_prefix_group_2_seg, 7);
    chk("rst_cnt", dec_prefix_count, 0);
    chk("rst_exc", dec_exception_gp, 0);
    chk("rst_len", dec_length, 0);
    q.delete(); refresh();
    tick();

    // single-byte NOP
    q = '{8'h90}; length_ready = 1; consume_length = 1; refresh();
    chk_acc("nop_pfx", 0); tick();
    chk_acc("nop_iss", 1); tick();
    chk("nop_valid", dec_valid, 1);
    chk("nop_len", dec_length, 1);
    chk("nop_seg", dec_prefix_group_2_seg, 7);
    tick();
    chk("nop_strobe", dec_valid, 0);

    // 66 2E 0F B6 C0
    q = '{8'h66, 8'h2E, 8'h0F, 8'hB6, 8'hC0}; consume_length = 2; refresh();
    chk_acc("mz_a0", 1); tick();
    chk_acc("mz_a1", 1); tick();
    chk_acc("mz_a2", 1); tick();
    chk_acc("mz_op", 0); tick();
    chk_acc("mz_iss", 2); tick();
    chk("mz_valid", dec_valid, 1);
    chk("mz_len", dec_length, 5);
    chk("mz_op32", dec_operand_32bit, 1);
    chk("mz_ad32", dec_address_32bit, 0);
    chk("mz_seg", dec_prefix_group_2_seg, 1);
    chk("mz_2b", dec_prefix_2byte, 1);
    chk("mz_cnt", dec_prefix_count, 3);
    tick();
    chk("mz_clr_cnt", dec_prefix_count, 0);
    chk("mz_clr_seg", dec_prefix_group_2_seg, 7);
    chk("mz_clr_op32", dec_operand_32bit, 0);

    // 0F 0F: second escape is the opcode
    q = '{8'h0F, 8'h0F}; consume_length = 1; refresh();
    chk_acc("esc_a0", 1); tick();
    chk_acc("esc_op", 0); tick();
    chk_acc("esc_iss", 1); tick();
    chk("esc_len", dec_length, 2);
    chk("esc_2b", dec_prefix_2byte, 1);
    tick();

    // F2 F3 26 64 90: last rep / last segment win
    q = '{8'hF2, 8'hF3, 8'h26, 8'h64, 8'h90}; consume_length = 1; refresh();
    for (int i = 0; i < 4; i++) begin chk_acc("rep_a", 1); tick(); end
    chk_acc("rep_op", 0); tick();
    chk_acc("rep_iss", 1); tick();
    chk("rep_rep", dec_prefix_group_1_rep, 1);
    chk("rep_seg", dec_prefix_group_2_seg, 4);
    chk("rep_cnt", dec_prefix_count, 4);
    chk("rep_len", dec_length, 5);
    tick();

    // 14 prefixes + 2-byte opcode = 16 bytes -> #GP
    for (int i = 0; i < 14; i++) q.push_back(8'h2E);
    q.push_back(8'h89); q.push_back(8'hC0);
    consume_length = 2; refresh();
    for (int i = 0; i < 14; i++) begin chk_acc("long_a", 1); tick(); end
    chk("long_cnt", dec_prefix_count, 14);
    chk_acc("long_op", 0); tick();
    chk_acc("long_iss", 0); tick();
    chk("long_gp", dec_exception_gp, 1);
    chk("long_gplen", dec_length, 0);
    chk("long_novalid", dec_valid, 0);
    chk_acc("long_hold0", 0); tick();
    chk("long_gp_once", dec_exception_gp, 0);
    chk_acc("long_hold1", 0); tick();
    chk_acc("long_hold2", 0);
    dec_flush = 1;
    chk_acc("long_fl_acc", 0); tick();
    dec_flush = 0;
    chk("long_fl_cnt", dec_prefix_count, 0);
    chk("long_fl_seg", dec_prefix_group_2_seg, 7);
    q.delete(); refresh(); tick();

    // 15 prefixes: the 15th leaves no room for an opcode
    for (int i = 0; i < 16; i++) q.push_back(8'h26);
    refresh();
    for (int i = 0; i < 15; i++) begin chk_acc("p15_a", 1); tick(); end
    chk("p15_gp", dec_exception_gp, 1);
    chk_acc("p15_hold", 0);
    dec_flush = 1; tick(); dec_flush = 0;
    chk("p15_fl_cnt", dec_prefix_count, 0);
    q.delete(); refresh(); tick();

    // micro_busy stall for 3 cycles
    q = '{8'h90}; consume_length = 1; micro_busy = 1; refresh();
    chk_acc("busy_pfx", 0); tick();
    for (int i = 0; i < 3; i++) begin chk_acc("busy_st", 0); tick(); end
    micro_busy = 0;
    chk_acc("busy_iss", 1); tick();
    chk("busy_valid", dec_valid, 1);
    tick();

    // fetch_valid 2 < consume_length 3
    q = '{8'h8B, 8'h45, 8'h08}; consume_length = 3; cap = 2; refresh();
    chk_acc("short_pfx", 0); tick();
    chk_acc("short_st0", 0); tick();
    chk_acc("short_st1", 0);
    cap = 8; refresh();
    chk_acc("short_iss", 3); tick();
    chk("short_valid", dec_valid, 1);
    chk("short_len", dec_length, 3);
    tick();

    // flush in the issue cycle
    q = '{8'h90}; consume_length = 1; refresh();
    chk_acc("fli_pfx", 0); tick();
    dec_flush = 1;
    chk_acc("fli_acc", 0); tick();
    dec_flush = 0;
    chk("fli_valid", dec_valid, 0);
    q.delete(); refresh(); tick();
    chk("fli_valid2", dec_valid, 0);

    // reset mid-prefix
    cs_db = 1;
    q = '{8'hF0, 8'h66, 8'h26, 8'h90}; refresh();
    for (int i = 0; i < 3; i++) begin chk_acc("rmp_a", 1); tick(); end
    chk("rmp_lock", dec_prefix_group_1_lock, 1);
    chk("rmp_seg", dec_prefix_group_2_seg, 0);
    chk("rmp_op32", dec_operand_32bit, 0);
    chk("rmp_ad32", dec_address_32bit, 1);
    rst = 1;
    chk_acc("rmp_acc", 0); tick();
    rst = 0;
    chk("rmp_cnt", dec_prefix_count, 0);
    chk("rmp_lock0", dec_prefix_group_1_lock, 0);
    chk("rmp_seg7", dec_prefix_group_2_seg, 7);
    chk("rmp_op32r", dec_operand_32bit, 1);
    chk("rmp_valid", dec_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
